// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation result path: packed-word
// field positions, vector width and the memory-writer FSM state encoding.
package me_pkg;

  localparam int MV_WIDTH = 6;

  localparam int MV_Y_MSB = 31;
  localparam int MV_Y_LSB = 26;
  localparam int MV_X_MSB = 25;
  localparam int MV_X_LSB = 20;
  localparam int SAD_LSB  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/me_result_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head is the entry at the read
// pointer and stays put until it is popped.
module me_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/me_mv_writer.sv
// Captures one ME result per data_valid rising edge, packs it into a 32-bit
// motion-vector word and streams the buffered words to the MV memory.
module me_mv_writer
  import me_pkg::*;
#(
  parameter int          SAD_BIT_WIDTH    = 14,
  parameter int          MV_OFFSET        = 8,
  parameter int          FIFO_DEPTH       = 4,
  parameter int          BLOCKS_PER_FRAME = 1024,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter int          ADDR_STEP        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SAD_BIT_WIDTH-1:0] msad_i,
  input  logic [4:0]               msad_column_i,
  input  logic [4:0]               msad_row_i,
  input  logic                     data_valid_i,
  output logic [31:0]              mv_mem_addr,
  output logic [31:0]              mv_mem_data,
  output logic                     mv_mem_we,
  input  logic                     mv_mem_ready,
  output logic [15:0]              block_count,
  output logic                     frame_done,
  output logic                     overflow,
  output wr_state_t                dbg_state_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic             dv_q;
  logic             push;
  logic             pop;
  logic [MV_WIDTH-1:0] mv_x, mv_y;
  logic [31:0]      packed_word;
  logic [31:0]      fifo_head;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;
  wr_state_t        state_q, state_d;
  logic [31:0]      addr_q;
  logic [15:0]      count_q;
  logic             frame_done_q;
  logic             overflow_q;

  assign push = data_valid_i & ~dv_q;
  assign pop  = (state_q == WRITE) & mv_mem_ready;

  // Column/row 0..31 minus the window origin always fits 6-bit two's complement.
  assign mv_x = {1'b0, msad_column_i} - MV_WIDTH'(MV_OFFSET);
  assign mv_y = {1'b0, msad_row_i}    - MV_WIDTH'(MV_OFFSET);

  always_comb begin
    packed_word = '0;
    packed_word[MV_Y_MSB:MV_Y_LSB] = mv_y;
    packed_word[MV_X_MSB:MV_X_LSB] = mv_x;
    packed_word[SAD_LSB +: SAD_BIT_WIDTH] = msad_i;
  end

  me_result_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (packed_word),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // A push into an empty FIFO is always accepted, so it can start the write
  // request one cycle after the edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty || push) state_d = WRITE;
      end
      WRITE: begin
        if (mv_mem_ready && (fifo_level == LW'(1)) && !push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q         <= 1'b0;
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      dv_q         <= data_valid_i;
      state_q      <= state_d;
      frame_done_q <= 1'b0;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      if (pop) begin
        if (count_q == 16'(BLOCKS_PER_FRAME - 1)) begin
          count_q      <= '0;
          addr_q       <= BASE_ADDR;
          frame_done_q <= 1'b1;
        end else begin
          count_q <= count_q + 16'd1;
          addr_q  <= addr_q + 32'(ADDR_STEP);
        end
      end
    end
  end

  assign mv_mem_we   = (state_q == WRITE);
  assign mv_mem_data = (state_q == WRITE) ? fifo_head : 32'h0;
  assign mv_mem_addr = addr_q;
  assign block_count = count_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_me_mv_writer.sv
// Directed bench for me_mv_writer: a vector table of results with hand-packed
// words plus sequences for backpressure, overflow, frame wrap and reset.
module tb_me_mv_writer;
  import me_pkg::*;

  localparam int BPF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] msad_i = '0;
  logic [4:0]  msad_column_i = '0;
  logic [4:0]  msad_row_i = '0;
  logic        data_valid_i = 1'b0;
  logic        mv_mem_ready = 1'b0;
  logic [31:0] mv_mem_addr, mv_mem_data;
  logic        mv_mem_we;
  logic [15:0] block_count;
  logic        frame_done, overflow;
  wr_state_t   dbg_state;

  me_mv_writer #(
    .SAD_BIT_WIDTH    (14),
    .MV_OFFSET        (8),
    .FIFO_DEPTH       (4),
    .BLOCKS_PER_FRAME (BPF),
    .BASE_ADDR        (32'h0000_0000),
    .ADDR_STEP        (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .msad_i        (msad_i),
    .msad_column_i (msad_column_i),
    .msad_row_i    (msad_row_i),
    .data_valid_i  (data_valid_i),
    .mv_mem_addr   (mv_mem_addr),
    .mv_mem_data   (mv_mem_data),
    .mv_mem_we     (mv_mem_we),
    .mv_mem_ready  (mv_mem_ready),
    .block_count   (block_count),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard entries are {addr, data} of writes the memory should accept.
  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int n_sent = 0;
  int bc_model = 0;
  bit fd_pending = 1'b0;
  int fd_seen = 0;

  typedef struct {
    logic [4:0]  col;
    logic [4:0]  row;
    logic [13:0] msad;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] next_addr();
    logic [31:0] a;
    a = 32'((n_sent % BPF) * 4);
    n_sent++;
    return a;
  endfunction

  // Memory-side monitor: checks every accepted write and the frame counters.
  always @(negedge clk) begin
    if (!rst) begin
      chk("block_count", 64'(block_count), 64'(bc_model));
      chk("frame_done", 64'(frame_done), 64'(fd_pending));
      if (frame_done) fd_seen++;
      fd_pending = 1'b0;
      if (mv_mem_we && mv_mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {mv_mem_addr, mv_mem_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("write_addr_data", {mv_mem_addr, mv_mem_data}, exp_q.pop_front());
        end
        bc_model = (bc_model + 1) % BPF;
        if (bc_model == 0) fd_pending = 1'b1;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    n_sent = 0;
    bc_model = 0;
    fd_pending = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    data_valid_i = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [4:0] col, input logic [4:0] row, input logic [13:0] msad);
    @(posedge clk);
    #1 msad_column_i = col;
    msad_row_i = row;
    msad_i = msad;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1 data_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] held_data;

    // mv_x/mv_y = {0,col}-8 / {0,row}-8 in 6 bits; word = {y, x, 6'b0, msad}
    vecs[0] = '{5'd8,  5'd8,  14'd300,    32'h0000_012C};
    vecs[1] = '{5'd0,  5'd3,  14'd5,      32'hEF80_0005};
    vecs[2] = '{5'd31, 5'd31, 14'h3FFF,   32'h5D70_3FFF};
    vecs[3] = '{5'd8,  5'd0,  14'd1,      32'hE000_0001};
    vecs[4] = '{5'd9,  5'd7,  14'h1234,   32'hFC10_1234};
    vecs[5] = '{5'd16, 5'd24, 14'h2000,   32'h4080_2000};

    // Reset state, sampled while reset is still applied.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", 64'(mv_mem_addr), 64'h0);
    chk("rst_data", 64'(mv_mem_data), 64'h0);
    chk("rst_we", 64'(mv_mem_we), 64'h0);
    chk("rst_block_count", 64'(block_count), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    do_reset();

    // Table vectors with ready high: one-cycle capture-to-request latency.
    mv_mem_ready = 1'b1;
    fd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({next_addr(), vecs[i].exp_data});
      @(posedge clk);
      #1 msad_column_i = vecs[i].col;
      msad_row_i = vecs[i].row;
      msad_i = vecs[i].msad;
      data_valid_i = 1'b1;
      @(negedge clk);
      chk("latency_we_low", 64'(mv_mem_we), 64'h0);
      @(posedge clk);
      #1 data_valid_i = 1'b0;
      @(negedge clk);
      chk("latency_we_high", 64'(mv_mem_we), 64'h1);
      chk("latency_data", 64'(mv_mem_data), 64'(vecs[i].exp_data));
      wait_drain("table_drain");
    end
    chk("table_fd_pulses", 64'(fd_seen), 64'd1);
    chk("table_block_count", 64'(block_count), 64'd2);

    // Level held for 10 cycles produces exactly one write.
    do_reset();
    exp_q.push_back({next_addr(), 32'hEF80_0000});
    @(posedge clk);
    #1 msad_column_i = 5'd0;
    msad_row_i = 5'd3;
    msad_i = 14'd0;
    data_valid_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 data_valid_i = 1'b0;
    wait_drain("hold_drain");
    chk("hold_block_count", 64'(block_count), 64'd1);

    // Backpressure: three results queued while ready is low.
    do_reset();
    mv_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({next_addr(), vecs[i + 2].exp_data});
      send(vecs[i + 2].col, vecs[i + 2].row, vecs[i + 2].msad);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_we", 64'(mv_mem_we), 64'h1);
      chk("bp_addr", 64'(mv_mem_addr), 64'h0);
      chk("bp_data", 64'(mv_mem_data), 64'h5D70_3FFF);
    end
    @(posedge clk);
    #1 mv_mem_ready = 1'b1;
    // Three consecutive accepts with ready held high.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_back_to_back", 64'(mv_mem_we), 64'h1);
    end
    wait_drain("bp_drain");

    // Overflow: five edges into a four-entry buffer, fifth is dropped.
    do_reset();
    mv_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({next_addr(), vecs[i].exp_data});
      send(vecs[i].col, vecs[i].row, vecs[i].msad);
    end
    @(negedge clk);
    chk("ovf_before_fifth", 64'(overflow), 64'h0);
    send(vecs[4].col, vecs[4].row, vecs[4].msad);
    @(negedge clk);
    chk("ovf_after_fifth", 64'(overflow), 64'h1);
    @(posedge clk);
    #1 mv_mem_ready = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // Frame wrap: fifth write returns to base address.
    do_reset();
    fd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({next_addr(), vecs[i].exp_data});
      send(vecs[i].col, vecs[i].row, vecs[i].msad);
    end
    wait_drain("wrap_drain");
    chk("wrap_fd_pulses", 64'(fd_seen), 64'd1);
    chk("wrap_block_count", 64'(block_count), 64'd1);
    chk("wrap_addr", 64'(mv_mem_addr), 64'd4);

    // Reset during a stalled write, with data_valid held through reset.
    do_reset();
    mv_mem_ready = 1'b0;
    @(posedge clk);
    #1 msad_column_i = 5'd5;
    msad_row_i = 5'd6;
    msad_i = 14'd7;
    data_valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_we_before_rst", 64'(mv_mem_we), 64'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_we", 64'(mv_mem_we), 64'h0);
    chk("mid_rst_addr", 64'(mv_mem_addr), 64'h0);
    chk("mid_rst_data", 64'(mv_mem_data), 64'h0);
    chk("mid_rst_block_count", 64'(block_count), 64'h0);
    chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    mv_mem_ready = 1'b1;
    exp_q.push_back({next_addr(), 32'hFBD0_0007});
    @(negedge clk);
    chk("recapture_we_low", 64'(mv_mem_we), 64'h0);
    @(negedge clk);
    chk("recapture_we_high", 64'(mv_mem_we), 64'h1);
    @(posedge clk);
    #1 data_valid_i = 1'b0;
    wait_drain("recapture_drain");
    chk("recapture_block_count", 64'(block_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
